// File: rtl/ula_pkg.sv
// Shared opcode definitions for the ula ALU slice.
package ula_pkg;

  typedef logic [2:0] ula_op_t;

  localparam ula_op_t OP_ADD = 3'b000;
  localparam ula_op_t OP_SUB = 3'b001;
  localparam ula_op_t OP_GT  = 3'b010;
  localparam ula_op_t OP_LT  = 3'b011;
  localparam ula_op_t OP_GE  = 3'b100;
  localparam ula_op_t OP_LE  = 3'b101;
  localparam ula_op_t OP_EQ  = 3'b110;
  localparam ula_op_t OP_MUL = 3'b111;

endpackage

// File: rtl/ula_compare.sv
// Combinational N-bit unsigned magnitude comparator; ge/le are derived by the caller.
module ula_compare #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/ula_alu.sv
// N-bit ALU: add/sub/multiply/compare with one registered stage,
// synchronous clear (highest priority), preset and hold enable.
module ula_alu
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           Tclk,
  input  logic           Tclr,
  input  logic           Tpr,
  input  logic           en,
  input  logic [N-1:0]   A_in,
  input  logic [N-1:0]   B_in,
  input  logic [2:0]     selec,
  output logic [N:0]     S,
  output logic [2*N-1:0] Smulti
);

  logic [N:0]     s_q, s_d, s_new;
  logic [2*N-1:0] m_q, m_d, m_new;
  logic           gt, lt, eq;

  ula_compare #(.N(N)) u_compare (
    .a  (A_in),
    .b  (B_in),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  // Every opcode drives exactly one output; the other is forced to zero.
  always_comb begin
    s_new = '0;
    m_new = '0;
    case (ula_op_t'(selec))
      OP_ADD:  s_new = {1'b0, A_in} + {1'b0, B_in};
      OP_SUB:  s_new = {1'b0, A_in} - {1'b0, B_in};
      OP_GT:   s_new = {{N{1'b0}}, gt};
      OP_LT:   s_new = {{N{1'b0}}, lt};
      OP_GE:   s_new = {{N{1'b0}}, gt | eq};
      OP_LE:   s_new = {{N{1'b0}}, lt | eq};
      OP_EQ:   s_new = {{N{1'b0}}, eq};
      OP_MUL:  m_new = {{N{1'b0}}, A_in} * {{N{1'b0}}, B_in};
      default: s_new = '0;
    endcase
  end

  always_comb begin
    s_d = s_q;
    m_d = m_q;
    if (Tclr) begin
      s_d = '0;
      m_d = '0;
    end else if (Tpr) begin
      s_d = '1;
      m_d = '1;
    end else if (en) begin
      s_d = s_new;
      m_d = m_new;
    end
  end

  always_ff @(posedge Tclk) begin
    s_q <= s_d;
    m_q <= m_d;
  end

  assign S      = s_q;
  assign Smulti = m_q;

endmodule

// File: tb/tb_ula_alu.sv
// Directed plus randomized self-check of ula_alu against an arithmetic reference model.
module tb_ula_alu;

  localparam int N     = 8;
  localparam int S_MOD = 1 << (N + 1);
  localparam int A_MAX = (1 << N) - 1;

  logic           Tclk = 1'b0;
  logic           Tclr = 1'b0;
  logic           Tpr  = 1'b0;
  logic           en   = 1'b0;
  logic [N-1:0]   A_in = '0;
  logic [N-1:0]   B_in = '0;
  logic [2:0]     selec = '0;
  logic [N:0]     S;
  logic [2*N-1:0] Smulti;

  int checks = 0;
  int errors = 0;
  int exp_s  = 0;
  int exp_m  = 0;

  ula_alu #(.N(N)) dut (
    .Tclk   (Tclk),
    .Tclr   (Tclr),
    .Tpr    (Tpr),
    .en     (en),
    .A_in   (A_in),
    .B_in   (B_in),
    .selec  (selec),
    .S      (S),
    .Smulti (Smulti)
  );

  always #5 Tclk = ~Tclk;

  // Reference: results derived from plain unsigned integer arithmetic.
  function automatic void ref_model(input int op, input int a, input int b,
                                    output int s, output int m);
    s = 0;
    m = 0;
    case (op)
      0: s = a + b;
      1: s = (a - b + S_MOD) % S_MOD;
      2: s = (a > b)  ? 1 : 0;
      3: s = (a < b)  ? 1 : 0;
      4: s = (a >= b) ? 1 : 0;
      5: s = (a <= b) ? 1 : 0;
      6: s = (a == b) ? 1 : 0;
      default: m = a * b;
    endcase
  endfunction

  task automatic drive(input logic clr, input logic pr, input logic e,
                       input int op, input int a, input int b);
    Tclr  = clr;
    Tpr   = pr;
    en    = e;
    selec = op[2:0];
    A_in  = a[N-1:0];
    B_in  = b[N-1:0];
    @(posedge Tclk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cmp_a[3]   = '{55, 200, 50};
  int cmp_b[3]   = '{100, 3, 50};
  int cmp_exp[5][3] = '{'{0, 1, 0}, '{1, 0, 0}, '{0, 1, 1}, '{1, 0, 1}, '{0, 0, 1}};

  initial begin
    int s_ref, m_ref;
    int op, a, b, r;
    logic clr, pr, e;

    // Reset and hold
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
    check("clr_s", int'(S), 0);
    check("clr_m", int'(Smulti), 0);
    drive(1'b0, 1'b0, 1'b0, 0, 5, 7);
    check("hold_s", int'(S), 0);
    drive(1'b0, 1'b0, 1'b1, 0, 5, 7);
    check("add_5_7", int'(S), 12);

    // Comparison table
    for (int o = 0; o < 5; o++) begin
      for (int p = 0; p < 3; p++) begin
        drive(1'b0, 1'b0, 1'b1, o + 2, cmp_a[p], cmp_b[p]);
        check($sformatf("cmp_op%0d_pair%0d", o + 2, p), int'(S), cmp_exp[o][p]);
        check($sformatf("cmp_op%0d_pair%0d_m", o + 2, p), int'(Smulti), 0);
      end
    end

    // Arithmetic boundaries
    drive(1'b0, 1'b0, 1'b1, 0, 255, 255);
    check("add_255_255", int'(S), 510);
    drive(1'b0, 1'b0, 1'b1, 1, 200, 3);
    check("sub_200_3", int'(S), 197);
    drive(1'b0, 1'b0, 1'b1, 1, 3, 200);
    check("sub_3_200", int'(S), 315);
    drive(1'b0, 1'b0, 1'b1, 1, 0, 1);
    check("sub_0_1", int'(S), 511);

    // Multiply
    drive(1'b0, 1'b0, 1'b1, 7, 255, 255);
    check("mul_255_m", int'(Smulti), 65025);
    check("mul_255_s", int'(S), 0);
    drive(1'b0, 1'b0, 1'b1, 7, 12, 11);
    check("mul_12_11", int'(Smulti), 132);
    drive(1'b0, 1'b0, 1'b1, 0, 1, 2);
    check("add_after_mul_m", int'(Smulti), 0);
    check("add_after_mul_s", int'(S), 3);

    // Preset and priority
    drive(1'b0, 1'b1, 1'b1, 0, 1, 1);
    check("pr_s", int'(S), 511);
    check("pr_m", int'(Smulti), 65535);
    drive(1'b1, 1'b1, 1'b1, 7, 9, 9);
    check("clr_pr_s", int'(S), 0);
    check("clr_pr_m", int'(Smulti), 0);
    drive(1'b0, 1'b1, 1'b0, 0, 1, 1);
    check("pr_noen_s", int'(S), 511);
    check("pr_noen_m", int'(Smulti), 65535);

    // Randomized sequence against the model
    exp_s = 511;
    exp_m = 65535;
    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 11);
      clr = (r == 0);
      pr  = (r == 1);
      e   = ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 7);
      a   = (r == 2) ? A_MAX : $urandom_range(0, A_MAX);
      b   = (r == 3) ? a : $urandom_range(0, A_MAX);
      if (clr) begin
        exp_s = 0;
        exp_m = 0;
      end else if (pr) begin
        exp_s = S_MOD - 1;
        exp_m = (1 << (2 * N)) - 1;
      end else if (e) begin
        ref_model(op, a, b, s_ref, m_ref);
        exp_s = s_ref;
        exp_m = m_ref;
      end
      drive(clr, pr, e, op, a, b);
      check($sformatf("rnd%0d_op%0d_%0d_%0d_s", i, op, a, b), int'(S), exp_s);
      check($sformatf("rnd%0d_op%0d_%0d_%0d_m", i, op, a, b), int'(Smulti), exp_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_alu.md
Name: ula_alu

Overview:
- Parameterised N-bit arithmetic/logic unit: add, subtract, multiply and five unsigned magnitude comparisons, selected by a 3-bit opcode.
- Results are registered on Tclk with synchronous clear, synchronous preset and a hold enable.
- Sits in the datapath as the single ALU; operands arrive combinationally, results are valid one cycle later.

Parameters:
- N, 8, operand width in bits (N >= 2).

Ports:
- Tclk  in  1  clock; all state updates on the rising edge.
- Tclr  in  1  synchronous active-high clear; highest priority.
- Tpr  in  1  synchronous active-high preset; second priority.
- en  in  1  update enable; low = hold both result registers.
- A_in  in  N  operand A, unsigned.
- B_in  in  N  operand B, unsigned.
- selec  in  3  opcode.
- S  out  N+1  registered result for add/sub/compare ops.
- Smulti  out  2N  registered product for the multiply op.

Behaviour:
- Single clock domain; one register stage; latency 1 cycle. Output is a function of the A_in/B_in/selec values sampled at the edge.
- Priority at each rising edge:
  - Tclr=1: S=0, Smulti=0.
  - Else Tpr=1: S=all ones, Smulti=all ones.
  - Else en=1: load new results.
  - Else: hold.
- Clear or preset mid-operation discards the in-flight result; no other internal state exists.
- Power-up value is undefined until the first Tclr.
- Opcodes (all unsigned):
  - 000 add: S = A+B, full N+1 bits; S[N] is carry. Smulti=0.
  - 001 subtract: S = A-B modulo 2^(N+1); S[N]=1 when A<B (borrow). Smulti=0.
  - 010 greater: S = {N zeros, A>B}. Smulti=0.
  - 011 less: S = {N zeros, A<B}. Smulti=0.
  - 100 greater-or-equal: S = {N zeros, A>=B}. Smulti=0.
  - 101 less-or-equal: S = {N zeros, A<=B}. Smulti=0.
  - 110 equal: S = {N zeros, A==B}. Smulti=0.
  - 111 multiply: Smulti = A*B, full 2N bits, no truncation. S=0.
- For every opcode, the output not used by that opcode is forced to 0 on the same load.
- Boundaries:
  - A=B=all ones with add gives S = 2^(N+1)-2.
  - A=0, B=1 with subtract gives S = all ones.
  - Multiply of all-ones operands gives (2^N-1)^2.
- No X propagation: an opcode change takes effect at the next enabled edge only.

Decomposition:
- Shared package ula_pkg:
  - 3-bit opcode localparams: OP_ADD, OP_SUB, OP_GT, OP_LT, OP_GE, OP_LE, OP_EQ, OP_MUL.
  - The corresponding typedef.
- One natural sub-module, ula_compare: combinational N-bit unsigned comparator. Outputs gt, lt and eq; ge/le are derived in the parent.
- Adder, subtractor, multiplier and output registers live in ula_alu.

Test Plan:
- Reset/hold:
  - Tclr=1 for one edge -> S=0, Smulti=0.
  - Then en=0 with opcode 000, A=5, B=7 -> S stays 0.
  - Then en=1 -> S=12 after one edge.
- Comparisons, opcodes 010 through 110, each with pairs (55,100), (200,3), (50,50) -> required S per pair:
  - 010 greater: 0, 1, 0.
  - 011 less: 1, 0, 0.
  - 100 greater-or-equal: 0, 1, 1.
  - 101 less-or-equal: 1, 0, 1.
  - 110 equal: 0, 0, 1.
  - Smulti=0 throughout.
- Arithmetic:
  - add 255+255 -> S=510.
  - sub 200-3 -> S=197.
  - sub 3-200 -> S=315 (bit 8 set as borrow).
- Multiply:
  - 255*255 -> Smulti=65025, S=0.
  - 12*11 -> Smulti=132.
- Preset/priority:
  - Tpr=1 -> S=511, Smulti=65535.
  - Tclr=1 and Tpr=1 together -> both 0.
  - Tpr=1 with en=0 -> preset still applies.
